// File: rtl/load_store_unit.sv
// Load/store unit: lane steering, load extension and a REQ handshake with watchdog.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses without a bus request.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        ls_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ls_stall,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] wd;

  logic        st_byte, st_half;
  logic        ld_byte, ld_half;
  logic        bad_align;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] load_ext;

  assign st_byte = funct3[1:0] == 2'b00;
  assign st_half = funct3[1:0] == 2'b01;
  assign ld_byte = f3_q[1:0] == 2'b00;
  assign ld_half = f3_q[1:0] == 2'b01;

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_align = (st_half & addr[0]) |
                     (~st_byte & ~st_half & (addr[1:0] != 2'b00));
`else
  assign bad_align = 1'b0;
`endif

  assign ls_stall = ls_valid && (state != DONE);
  assign mem_req  = state == REQ;
  assign mem_we   = (state == REQ) && we_q;

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = wdata;
    unique case (1'b1)
      st_byte: begin
        be_nx    = 4'b0001 << addr[1:0];
        wdata_nx = {4{wdata[7:0]}};
      end
      st_half: begin
        be_nx    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nx = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lanes come from the latched offset; funct3[2] selects zero-extension.
  always_comb begin
    lb       = mem_rdata[{off_q, 3'b000} +: 8];
    lh       = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_ext = mem_rdata;
    unique case (1'b1)
      ld_byte: load_ext = {{24{~f3_q[2] & lb[7]}}, lb};
      ld_half: load_ext = {{16{~f3_q[2] & lh[15]}}, lh};
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (ls_valid) state_nx = bad_align ? DONE : REQ;
      REQ:  if (mem_ready || wd == WD_LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      wd        <= '0;
      rdata     <= 32'h0;
      bus_err   <= 1'b0;
      misalign  <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      state    <= state_nx;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
      unique case (state)
        IDLE: if (ls_valid) begin
          we_q      <= ls_we;
          f3_q      <= funct3;
          off_q     <= addr[1:0];
          mem_addr  <= {addr[31:2], 2'b00};
          mem_be    <= ls_we ? be_nx : 4'b1111;
          mem_wdata <= wdata_nx;
          if (bad_align) begin
            misalign <= 1'b1;
            rdata    <= 32'h0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            rdata <= we_q ? 32'h0 : load_ext;
            wd    <= '0;
          end else if (wd == WD_LAST) begin
            bus_err <= 1'b1;
            rdata   <= 32'h0;
            wd      <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory responder.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid, ls_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ls_stall, bus_err, misalign;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .ls_valid(ls_valid), .ls_we(ls_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .ls_stall(ls_stall), .bus_err(bus_err), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        berr;
    logic        mis;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int passes = 0;
  int cur_lat = 0;
  logic [31:0] cur_word = 32'h0;
  int wait_cnt = 0;
  int stall_cnt = 0;
  bit req_seen = 0;
  bit after_done = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] word, input int lat);
    exp_t e;
    int w, off;
    bit trap, tmo;
    logic [31:0] v, m;
    w   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = (w == 4) ? 0 : (w == 2) ? 2 * int'(a[1]) : int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (a % w) != 0;
`else
    trap = 0;
`endif
    tmo = !trap && lat >= TO;
    e.maddr = a - (a % 4);
    e.we = we;
    e.req = !trap;
    e.be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (!we || (i >= off && i < off + w)) e.be[i] = 1'b1;
      e.mwdata[8*i +: 8] = wd[8*(i % w) +: 8];
    end
    m = (w == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * w)) - 1;
    v = (word >> (8 * off)) & m;
    if (!f3[2] && w < 4 && v[8*w-1]) v = v | ~m;
    e.berr  = tmo;
    e.mis   = trap;
    e.stall = trap ? 1 : tmo ? TO + 1 : lat + 2;
    e.rdata = (trap || tmo || we) ? 32'h0 : v;
    return e;
  endfunction

  // Memory responder: ready after cur_lat wait cycles in REQ.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      mem_ready = (wait_cnt == cur_lat);
      mem_rdata = mem_ready ? cur_word : $urandom;
      wait_cnt++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      stall_cnt = 0;
      req_seen = 0;
      after_done = 0;
    end else begin
      if (after_done) begin
        chk("pulse_clear", {30'b0, bus_err, misalign}, 32'h0);
        after_done = 0;
      end
      if (ls_valid && ls_stall) begin
        stall_cnt++;
        if (mem_req) begin
          req_seen = 1;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_req got=1 want=0");
          end else begin
            mon_e = exp_q[0];
            chk("mem_addr", mem_addr, mon_e.maddr);
            chk("mem_be", {28'b0, mem_be}, {28'b0, mon_e.be});
            chk("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
            if (mon_e.we) chk("mem_wdata", mem_wdata, mon_e.mwdata);
          end
        end
      end else if (ls_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done got=1 want=0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("rdata", rdata, mon_e.rdata);
          chk("bus_err", {31'b0, bus_err}, {31'b0, mon_e.berr});
          chk("misalign", {31'b0, misalign}, {31'b0, mon_e.mis});
          chk("stall_cycles", stall_cnt, mon_e.stall);
          chk("req_seen", {31'b0, req_seen}, {31'b0, mon_e.req});
        end
        stall_cnt = 0;
        req_seen = 0;
        after_done = 1;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int lat,
                       input int gap);
    bit done;
    exp_q.push_back(model(we, f3, a, wd, word, lat));
    cur_lat = lat;
    cur_word = word;
    ls_valid = 1'b1;
    ls_we = we;
    funct3 = f3;
    addr = a;
    wdata = wd;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!ls_stall) done = 1;
    end
    if (!done) begin
      checks++;
      $display("FAIL done_bound got=stalled want=released");
    end
    @(posedge clk);
    #1;
    if (gap > 0) begin
      ls_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_req_we"}, {30'b0, mem_req, mem_we}, 32'h0);
    chk({tag, "_be"}, {28'b0, mem_be}, 32'h0);
    chk({tag, "_maddr"}, mem_addr, 32'h0);
    chk({tag, "_mwdata"}, mem_wdata, 32'h0);
    chk({tag, "_flags"}, {30'b0, bus_err, misalign}, 32'h0);
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    reset = 1'b1;
    ls_valid = 1'b0;
    ls_we = 1'b0;
    funct3 = 3'b000;
    addr = 32'h0;
    wdata = 32'h0;
    #2;
    check_zero("reset");
    chk("reset_stall", {31'b0, ls_stall}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset while a load waits in REQ.
    cur_lat = 255;
    ls_valid = 1'b1;
    funct3 = 3'b010;
    addr = 32'h0000_2004;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_req", {31'b0, mem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check_zero("midreset");
    ls_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1;
    @(posedge clk);
    #1;

    issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 1);
    issue(1'b0, 3'b000, 32'h0000_1002, 32'h0, 32'h1280_3456, 0, 0);
    issue(1'b0, 3'b100, 32'h0000_1002, 32'h0, 32'h1280_3456, 1, 0);
    issue(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h1280_3456, 0, 1);
    issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 3, 1);
    issue(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1111_2222, 255, 1);
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, TO - 1, 1);
    issue(1'b0, 3'b010, 32'h0000_1001, 32'h0, 32'hCAFE_F00D, 0, 1);
    issue(1'b1, 3'b001, 32'h0000_1003, 32'h0000_BEEF, 32'h0, 0, 1);
    issue(1'b1, 3'b010, 32'h0000_3008, 32'h0102_0304, 32'h0, 2, 0);

    for (int n = 0; n < 60; n++) begin
      int lat;
      lat = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 3));
      issue(1'(($urandom_range(0, 2)) == 0), f3s[$urandom_range(0, 7)],
            $urandom, $urandom, $urandom, lat, int'($urandom_range(0, 1)));
    end

    ls_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle datapath's data-memory outputs (write address, write data, read data) and a handshaked data memory or bus.
- Converts a core load/store into a word-aligned memory transaction. Generates byte enables and lane-replicated store data, then sign- or zero-extends load data.
- Asserts a stall to freeze PC and register-file write until the transaction completes.
- A watchdog bounds every transaction.

Parameters:
- TIMEOUT, 16, max cycles waiting for mem_ready in REQ before aborting with bus_err
- CNT_W, 5, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- ls_valid  input  1  current instruction is a load or store
- ls_we  input  1  1 = store, 0 = load
- funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address from ALU result
- wdata  input  32  store data from register rs2
- rdata  output  32  extended load result, valid while the state is DONE
- ls_stall  output  1  core must hold PC and suppress RegWrite
- bus_err  output  1  pulse in DONE when the watchdog expired
- misalign  output  1  pulse in DONE on a misaligned access (feature dependent)
- mem_req  output  1  request strobe to memory
- mem_we  output  1  write strobe
- mem_be  output  4  byte enables
- mem_addr  output  32  word address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_ready  input  1  memory accepted the write / read data valid
- mem_rdata  input  32  raw memory word

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset state: IDLE. Reset values: rdata=0, bus_err=0, misalign=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, watchdog=0.
- ls_stall is combinational: ls_valid && state!=DONE.
- IDLE: on ls_valid, latch ls_we, funct3, addr[1:0], mem_addr, mem_be and mem_wdata, then go to REQ. The core holds its inputs during the stall.
- REQ: mem_req=1 and mem_we=latched ls_we. All mem_* outputs are stable until mem_ready.
  - Watchdog increments every REQ cycle.
  - On mem_ready: capture the extended load into rdata (stores: rdata=0), clear the watchdog, go to DONE.
  - If the watchdog reaches TIMEOUT without mem_ready: drop mem_req, set bus_err=1, rdata=0, go to DONE.
- DONE: ls_stall=0 and the core advances at this edge. bus_err and misalign are valid for this cycle only. Next state is IDLE.
- Minimum access: 3 cycles (2 stall cycles, plus 1 per wait cycle of mem_ready).
- Back-to-back memory instructions restart from IDLE.
- Store lanes:
  - SB: mem_be = 4'b0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111; mem_wdata = wdata.
- Loads always drive mem_be=1111.
- Load extraction: select the byte by addr[1:0] and the half by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Undefined funct3 (011, 110, 111) is treated as word width.
- ls_valid dropping during REQ (not legal) is ignored; the transaction completes.
- Reset asserted mid-transaction forces IDLE and drops mem_req in the same cycle, without waiting for a clock edge.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no memory request.
  - IDLE goes directly to DONE (one stall cycle), with misalign=1, rdata=0 and no write.
- Undefined:
  - misalign is tied to 0.
  - Misaligned accesses proceed with the offending low bits ignored (half uses addr[1]; word ignores addr[1:0]).

Test Plan:
- Reset mid-transaction: reset asserted in REQ with mem_ready low -> mem_req=0 immediately, state IDLE, all outputs 0.
- SB: addr=0x0000_1003, wdata=0x0000_00A5, mem_ready one cycle after req -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000, ls_stall high exactly 2 cycles.
- LB: addr=0x1002, mem_rdata=0x1280_3456 -> rdata=0xFFFF_FF80. LBU at the same address -> rdata=0x0000_0080. LH at addr=0x1002 -> rdata=0x0000_1280.
- Wait states: LW with mem_ready delayed 3 cycles, mem_rdata=0xDEAD_BEEF -> stall for 5 cycles, rdata=0xDEAD_BEEF in DONE, mem outputs stable throughout REQ.
- Timeout: mem_ready held low, TIMEOUT=16 -> mem_req drops after 16 REQ cycles, bus_err pulses for 1 cycle, rdata=0, stall releases.
- Misaligned LW at addr=0x1001:
  - With LSU_MISALIGN_TRAP_EN: no mem_req, misalign=1, one stall cycle.
  - Without: mem_addr=0x1000, rdata=mem_rdata, misalign=0.
